// File: rtl/l1_tlb_refill_ctrl.sv
// 8-entry L1 TLB: tag/PPN/permission store, 0-cycle lookup, and the
// miss -> L2 request -> refill controller that feeds L1_except_detec.
module l1_tlb_refill_ctrl #(
   parameter int VPN_BITS = 27,
   parameter int PPN_BITS = 20,
   parameter int ENTRIES  = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                io_req_valid,
   output logic                io_req_ready,
   input  logic [VPN_BITS-1:0] io_req_vpn,
   input  logic                io_req_bits_store,
   input  logic                io_vm_enabled,
   input  logic                io_sfence_valid,
   output logic                io_resp_miss,
   output logic [PPN_BITS-1:0] io_resp_ppn,
   output logic [ENTRIES:0]    hits,
   output logic [ENTRIES-1:0]  u_array,
   output logic [ENTRIES-1:0]  sw_array,
   output logic [ENTRIES-1:0]  sx_array,
   output logic [ENTRIES-1:0]  sr_array,
   output logic [ENTRIES-1:0]  xr_array,
   output logic [ENTRIES-1:0]  dirty_array,
   input  logic [ENTRIES:0]    dirty_hit_check,
   output logic                io_l2_req_valid,
   input  logic                io_l2_req_ready,
   output logic [VPN_BITS-1:0] io_l2_req_vpn,
   input  logic                io_l2_resp_valid,
   input  logic [PPN_BITS-1:0] io_l2_resp_ppn,
   input  logic                io_l2_resp_u,
   input  logic                io_l2_resp_sw,
   input  logic                io_l2_resp_sx,
   input  logic                io_l2_resp_sr,
   input  logic                io_l2_resp_xr,
   input  logic                io_l2_resp_d,
   input  logic                io_l2_resp_pf
);
   localparam int IW = $clog2(ENTRIES);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t                             state_q, state_d;
   logic [ENTRIES-1:0]                 valid_q, valid_d;
   logic [ENTRIES-1:0][VPN_BITS-1:0]   tag_q, tag_d;
   logic [ENTRIES-1:0][PPN_BITS-1:0]   ppn_q, ppn_d;
   logic [ENTRIES-1:0]                 u_q, u_d, sw_q, sw_d, sx_q, sx_d;
   logic [ENTRIES-1:0]                 sr_q, sr_d, xr_q, xr_d, d_q, d_d;
   logic [VPN_BITS-1:0]                miss_vpn_q, miss_vpn_d;
   logic [IW-1:0]                      idx_q, idx_d, rr_q, rr_d;
   logic                               from_rr_q, from_rr_d;
   logic                               kill_q, kill_d;

   logic [ENTRIES-1:0]  hits_lo;
   logic                dirty_fail, miss, has_inv;
   logic [IW-1:0]       hit_idx, inv_idx;
   logic [PPN_BITS-1:0] ppn_or;

   // Lookup: tag compare, hit encode, lowest invalid slot, OR of hit PPNs.
   // The store type is already folded into dirty_hit_check upstream.
   always_comb begin
      hit_idx = '0;
      inv_idx = '0;
      has_inv = 1'b0;
      ppn_or  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hits_lo[i] = valid_q[i] & (tag_q[i] == io_req_vpn) & io_vm_enabled;
         if (hits_lo[i]) begin
            hit_idx = IW'(i);
            ppn_or  = ppn_or | ppn_q[i];
         end
      end
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            inv_idx = IW'(i);
            has_inv = 1'b1;
         end
      end
   end

   assign hits         = {~io_vm_enabled, hits_lo};
   // hits[8] is only set with VM off, where miss is masked anyway.
   assign dirty_fail   = |(hits & ~dirty_hit_check);
   assign miss         = io_req_valid & io_vm_enabled & ((hits_lo == '0) | dirty_fail);
   assign io_req_ready = (state_q == S_IDLE);
   assign io_resp_miss = miss | (io_req_valid & ~io_req_ready) | (io_req_bits_store & 1'b0);
   assign io_resp_ppn  = io_vm_enabled ? ppn_or : io_req_vpn[PPN_BITS-1:0];
   assign io_l2_req_valid = (state_q == S_REQ);
   assign io_l2_req_vpn   = miss_vpn_q;
   assign u_array     = u_q;
   assign sw_array    = sw_q;
   assign sx_array    = sx_q;
   assign sr_array    = sr_q;
   assign xr_array    = xr_q;
   assign dirty_array = d_q;

   // Next-state: miss capture, L2 handshake, refill write and sfence flush.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      ppn_d      = ppn_q;
      u_d        = u_q;
      sw_d       = sw_q;
      sx_d       = sx_q;
      sr_d       = sr_q;
      xr_d       = xr_q;
      d_d        = d_q;
      miss_vpn_d = miss_vpn_q;
      idx_d      = idx_q;
      from_rr_d  = from_rr_q;
      rr_d       = rr_q;
      kill_d     = kill_q;
      case (state_q)
         S_IDLE: begin
            if (miss) begin
               miss_vpn_d = io_req_vpn;
               state_d    = S_REQ;
               // Reusing the hit slot on a dirty miss keeps tags unique.
               if (dirty_fail) begin
                  idx_d     = hit_idx;
                  from_rr_d = 1'b0;
               end else if (has_inv) begin
                  idx_d     = inv_idx;
                  from_rr_d = 1'b0;
               end else begin
                  idx_d     = rr_q;
                  from_rr_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (io_l2_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (io_l2_resp_valid) begin
               if (!io_l2_resp_pf && !kill_q && !io_sfence_valid) begin
                  valid_d[idx_q] = 1'b1;
                  tag_d[idx_q]   = miss_vpn_q;
                  ppn_d[idx_q]   = io_l2_resp_ppn;
                  u_d[idx_q]     = io_l2_resp_u;
                  sw_d[idx_q]    = io_l2_resp_sw;
                  sx_d[idx_q]    = io_l2_resp_sx;
                  sr_d[idx_q]    = io_l2_resp_sr;
                  xr_d[idx_q]    = io_l2_resp_xr;
                  d_d[idx_q]     = io_l2_resp_d;
                  if (from_rr_q) rr_d = rr_q + IW'(1);
               end
               kill_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush wins over a same-cycle refill; an in-flight walk is poisoned.
      if (io_sfence_valid) begin
         valid_d = '0;
         if (state_q != S_IDLE && !(state_q == S_WAIT && io_l2_resp_valid))
            kill_d = 1'b1;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         valid_q    <= '0;
         tag_q      <= '0;
         ppn_q      <= '0;
         u_q        <= '0;
         sw_q       <= '0;
         sx_q       <= '0;
         sr_q       <= '0;
         xr_q       <= '0;
         d_q        <= '0;
         miss_vpn_q <= '0;
         idx_q      <= '0;
         from_rr_q  <= 1'b0;
         rr_q       <= '0;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         ppn_q      <= ppn_d;
         u_q        <= u_d;
         sw_q       <= sw_d;
         sx_q       <= sx_d;
         sr_q       <= sr_d;
         xr_q       <= xr_d;
         d_q        <= d_d;
         miss_vpn_q <= miss_vpn_d;
         idx_q      <= idx_d;
         from_rr_q  <= from_rr_d;
         rr_q       <= rr_d;
         kill_q     <= kill_d;
      end
   end
endmodule

// File: tb/tb_l1_tlb_refill_ctrl.sv
// Directed bench for l1_tlb_refill_ctrl: fill, victim choice, dirty miss,
// sfence, page fault, VM bypass and mid-walk reset.
module tb_l1_tlb_refill_ctrl;
   logic        clock = 0, reset = 1;
   logic        io_req_valid = 0, io_req_ready, io_req_bits_store = 0;
   logic [26:0] io_req_vpn = 0;
   logic        io_vm_enabled = 1, io_sfence_valid = 0, io_resp_miss;
   logic [19:0] io_resp_ppn;
   logic [8:0]  hits, dirty_hit_check = 9'h1FF;
   logic [7:0]  u_array, sw_array, sx_array, sr_array, xr_array, dirty_array;
   logic        io_l2_req_valid, io_l2_req_ready = 0;
   logic [26:0] io_l2_req_vpn;
   logic        io_l2_resp_valid = 0;
   logic [19:0] io_l2_resp_ppn = 0;
   logic        io_l2_resp_u = 0, io_l2_resp_sw = 0, io_l2_resp_sx = 0;
   logic        io_l2_resp_sr = 0, io_l2_resp_xr = 0, io_l2_resp_d = 0, io_l2_resp_pf = 0;
   int n_cmp = 0, n_err = 0;

   l1_tlb_refill_ctrl dut (
      .clock(clock), .reset(reset), .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
      .io_req_vpn(io_req_vpn), .io_req_bits_store(io_req_bits_store),
      .io_vm_enabled(io_vm_enabled), .io_sfence_valid(io_sfence_valid),
      .io_resp_miss(io_resp_miss), .io_resp_ppn(io_resp_ppn), .hits(hits),
      .u_array(u_array), .sw_array(sw_array), .sx_array(sx_array), .sr_array(sr_array),
      .xr_array(xr_array), .dirty_array(dirty_array), .dirty_hit_check(dirty_hit_check),
      .io_l2_req_valid(io_l2_req_valid), .io_l2_req_ready(io_l2_req_ready),
      .io_l2_req_vpn(io_l2_req_vpn), .io_l2_resp_valid(io_l2_resp_valid),
      .io_l2_resp_ppn(io_l2_resp_ppn), .io_l2_resp_u(io_l2_resp_u),
      .io_l2_resp_sw(io_l2_resp_sw), .io_l2_resp_sx(io_l2_resp_sx),
      .io_l2_resp_sr(io_l2_resp_sr), .io_l2_resp_xr(io_l2_resp_xr),
      .io_l2_resp_d(io_l2_resp_d), .io_l2_resp_pf(io_l2_resp_pf));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a lookup and let combinational outputs settle.
   task automatic look(input logic [26:0] vpn, input logic st);
      io_req_valid = 1; io_req_vpn = vpn; io_req_bits_store = st;
      #1;
   endtask

   // Full miss/refill round trip from IDLE.
   task automatic refill(input logic [26:0] vpn, input logic [19:0] ppn,
                         input logic u, input logic d, input logic pf);
      look(vpn, 0);
      tick();
      io_req_valid = 0; io_l2_req_ready = 1;
      tick();
      io_l2_req_ready = 0; io_l2_resp_valid = 1; io_l2_resp_ppn = ppn;
      io_l2_resp_u = u; io_l2_resp_d = d; io_l2_resp_pf = pf;
      tick();
      io_l2_resp_valid = 0; io_l2_resp_pf = 0; io_l2_resp_u = 0; io_l2_resp_d = 0;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_ready", io_req_ready, 1);
      chk("rst_l2v", io_l2_req_valid, 0);
      chk("rst_miss", io_resp_miss, 0);
      chk("rst_u", u_array, 0);
      tick(); reset = 0; tick();

      // First miss and refill into entry 0
      look(27'h123, 0);
      chk("m1_miss", io_resp_miss, 1);
      chk("m1_hits", hits, 9'h000);
      tick(); io_req_valid = 0; #1;
      chk("m1_l2v", io_l2_req_valid, 1);
      chk("m1_l2vpn", io_l2_req_vpn, 27'h123);
      chk("m1_ready", io_req_ready, 0);
      io_l2_req_ready = 1; tick(); io_l2_req_ready = 0;
      chk("m1_wait_l2v", io_l2_req_valid, 0);
      io_l2_resp_valid = 1; io_l2_resp_ppn = 20'hABC; io_l2_resp_u = 1; io_l2_resp_d = 1;
      tick(); io_l2_resp_valid = 0; io_l2_resp_u = 0; io_l2_resp_d = 0;
      look(27'h123, 0);
      chk("m1_hit", hits, 9'h001);
      chk("m1_ppn", io_resp_ppn, 20'hABC);
      chk("m1_nomiss", io_resp_miss, 0);
      chk("m1_u", u_array, 8'h01);
      chk("m1_d", dirty_array, 8'h01);
      io_req_valid = 0;

      // Fill entries 1..7 (lowest invalid), then round-robin victims
      for (int i = 1; i < 8; i++) refill(27'h200 + 27'(i), 20'h100 + 20'(i), 0, 0, 0);
      look(27'h205, 0);
      chk("fill_hit5", hits, 9'h020);
      chk("fill_ppn5", io_resp_ppn, 20'h105);
      io_req_valid = 0;
      refill(27'h300, 20'h300, 0, 0, 0);
      look(27'h300, 0);
      chk("rr0_hit", hits, 9'h001);
      look(27'h123, 0);
      chk("rr0_evict", io_resp_miss, 1);
      io_req_valid = 0;
      refill(27'h301, 20'h301, 0, 0, 0);
      look(27'h301, 0);
      chk("rr1_hit", hits, 9'h002);
      io_req_valid = 0;

      // Store to clean entry 3 -> dirty miss, refilled in place
      dirty_hit_check = 9'h1F7;
      look(27'h203, 1);
      chk("dm_hits", hits, 9'h008);
      chk("dm_miss", io_resp_miss, 1);
      refill(27'h203, 20'h333, 0, 1, 0);
      dirty_hit_check = 9'h1FF;
      chk("dm_darr", dirty_array, 8'h08);
      look(27'h203, 0);
      chk("dm_hit", hits, 9'h008);
      chk("dm_ppn", io_resp_ppn, 20'h333);
      io_req_valid = 0;
      // rr_ptr was not advanced by the dirty refill -> victim is entry 2
      refill(27'h302, 20'h302, 0, 0, 0);
      look(27'h302, 0);
      chk("rr2_hit", hits, 9'h004);
      io_req_valid = 0;

      // sfence during WAIT discards the response
      look(27'h400, 0);
      tick(); io_req_valid = 0; io_l2_req_ready = 1; tick(); io_l2_req_ready = 0;
      io_sfence_valid = 1; io_req_vpn = 27'h302; #1;
      chk("sf_preflush", hits, 9'h004);
      tick(); io_sfence_valid = 0; #1;
      chk("sf_flushed", hits, 9'h000);
      chk("sf_still_wait", io_req_ready, 0);
      io_l2_resp_valid = 1; io_l2_resp_ppn = 20'h444;
      tick(); io_l2_resp_valid = 0;
      chk("sf_idle", io_req_ready, 1);
      look(27'h400, 0);
      chk("sf_nofill", hits, 9'h000);
      chk("sf_miss", io_resp_miss, 1);
      io_req_valid = 0;

      // Page fault: no fill
      refill(27'h500, 20'h555, 1, 1, 1);
      look(27'h500, 0);
      chk("pf_miss", io_resp_miss, 1);
      chk("pf_u", u_array, 8'h00);
      // VM bypass
      io_vm_enabled = 0;
      look(27'h7ABCDEF, 0);
      chk("vm_hits", hits, 9'h100);
      chk("vm_miss", io_resp_miss, 0);
      chk("vm_ppn", io_resp_ppn, 20'hBCDEF);
      io_vm_enabled = 1; io_req_valid = 0;

      // Reset mid-REQ drops the request at once
      look(27'h600, 0);
      tick(); io_req_valid = 0; #1;
      chk("rq_l2v", io_l2_req_valid, 1);
      reset = 1; #1;
      chk("rq_rst_l2v", io_l2_req_valid, 0);
      tick(); reset = 0;
      // Reset mid-WAIT: later response ignored
      look(27'h600, 0);
      tick(); io_req_valid = 0; io_l2_req_ready = 1; tick(); io_l2_req_ready = 0;
      reset = 1; #1;
      chk("wt_rst_l2v", io_l2_req_valid, 0);
      tick(); reset = 0; #1;
      chk("wt_ready", io_req_ready, 1);
      io_l2_resp_valid = 1; io_l2_resp_ppn = 20'h666;
      tick(); io_l2_resp_valid = 0;
      look(27'h600, 0);
      chk("wt_nofill", hits, 9'h000);
      chk("wt_miss", io_resp_miss, 1);
      io_req_valid = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/l1_tlb_refill_ctrl.md
Name: l1_tlb_refill_ctrl

Overview:
- 8-entry L1 TLB entry store, lookup, and miss/refill controller. Sits directly upstream of L1_except_detec.
- Produces the per-entry permission arrays and the `hits` vector that L1_except_detec consumes.
- Consumes L1_except_detec's `dirty_hit_check` to turn stores to clean pages into misses.
- Fetches missing translations from the L2 TLB over a valid/ready request and valid response, then refills an L1 entry.

Parameters:
- VPN_BITS, 27, virtual page number width.
- PPN_BITS, 20, physical page number width.
- ENTRIES, 8, L1 entry count; fixed at 8 to match the 8-bit permission arrays.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- io_req_valid  in  1  translation request.
- io_req_ready  out  1  high only in IDLE.
- io_req_vpn  in  VPN_BITS  lookup VPN.
- io_req_bits_store  in  1  request is a store.
- io_vm_enabled  in  1  translation on; when 0, hits[8]=1 and the lookup bypasses.
- io_sfence_valid  in  1  flush all entries.
- io_resp_miss  out  1  request not satisfied this cycle.
- io_resp_ppn  out  PPN_BITS  PPN of the hit entry; equals io_req_vpn[PPN_BITS-1:0] when VM is off.
- hits  out  9  one-hot hit vector; bit 8 = VM bypass.
- u_array, sw_array, sx_array, sr_array, xr_array, dirty_array  out  8 each  stored permission bits per entry.
- dirty_hit_check  in  9  from L1_except_detec.
- io_l2_req_valid  out  1  L2 request.
- io_l2_req_ready  in  1  L2 accepts.
- io_l2_req_vpn  out  VPN_BITS  captured miss VPN.
- io_l2_resp_valid  in  1  L2 response.
- io_l2_resp_ppn  in  PPN_BITS  refill PPN.
- io_l2_resp_u, io_l2_resp_sw, io_l2_resp_sx, io_l2_resp_sr, io_l2_resp_xr, io_l2_resp_d  in  1 each  refill permission bits.
- io_l2_resp_pf  in  1  page fault; no fill.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; all valid bits 0; all tags, PPNs and arrays 0.
  - rr_ptr=0; kill=0; io_l2_req_valid=0; io_resp_miss=0.
- Lookup (combinational, 0 latency):
  - hits[i] = valid[i] & tag[i]==io_req_vpn & io_vm_enabled, for i in 0..7.
  - hits[8] = ~io_vm_enabled.
  - A tag matching more than one entry is impossible by construction: the refill policy below never fills a duplicate tag.
- Miss condition:
  - miss = io_req_valid & io_vm_enabled & ( hits[7:0]==0 | dirty_fail ).
  - dirty_fail = |(hits[7:0] & ~dirty_hit_check[7:0]).
  - io_resp_miss = miss | (io_req_valid & ~io_req_ready).
  - io_resp_ppn = OR of ppn[i] over hit entries.
- FSM:
  - IDLE: on io_req_valid & miss, capture vpn into miss_vpn. Capture the refill index: the hit index if dirty_fail; otherwise the lowest invalid entry; otherwise rr_ptr. Go to REQ.
  - REQ: io_l2_req_valid=1 with io_l2_req_vpn=miss_vpn. On io_l2_req_ready go to WAIT.
  - WAIT: on io_l2_resp_valid, write the refill index unless io_l2_resp_pf, kill, or io_sfence_valid is set.
    - Written fields: valid=1, tag=miss_vpn, ppn, u, sw, sx, sr, xr, dirty=io_l2_resp_d.
    - rr_ptr increments mod 8 only when the victim came from rr_ptr.
    - Clear kill; go to IDLE.
- Refill effect is visible to lookup the cycle after the write, so the requester retries.
- sfence:
  - Clears all valid bits next edge, in any state.
  - In REQ or WAIT it also sets kill, so the in-flight response is discarded.
  - sfence and a refill in the same cycle: sfence wins; the entry stays invalid.
  - Lookup in the sfence cycle uses pre-flush contents.
- Responses arriving in IDLE or REQ are ignored.
- Reset asserted mid-REQ or mid-WAIT: immediate return to IDLE; a later L2 response is ignored.

Test Plan:
- Reset, vm=1, request vpn 0x123 -> miss=1, hits=0. Next cycle io_l2_req_valid=1 with vpn 0x123. Ready, then resp ppn 0xABC, u=1, d=1 -> entry 0 written. Retry -> hits=9'h001, ppn=0xABC, miss=0.
- Fill all 8 entries, then miss on a 9th vpn -> victim is entry 0 (rr_ptr=0). Next full-array miss -> victim entry 1.
- Store to a hit entry with d=0, dirty_hit_check[3]=0 -> miss=1. Refill overwrites entry 3 with d=1; no duplicate tag created.
- sfence pulsed in WAIT, then resp valid -> no entry written, all valid=0, state returns to IDLE.
- L2 resp with pf=1 -> no fill, retry still misses. vm=0 -> hits=9'h100, miss=0, ppn=vpn[19:0].
- Reset asserted during WAIT -> io_l2_req_valid=0 at once, a later response is ignored, io_req_ready=1 after reset deasserts.
